// File: rtl/nx_tcam_multibank_scrub_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : nx_tcam_multibank_scrub_seq_if
// Brief    : Request/grant and read-return bus between the scrub sequencer
//            (master) and the per-bank TCAM wrappers (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface nx_tcam_multibank_scrub_seq_if #(
   parameter int N_BANKS      = 4,
   parameter int N_ENTRIES    = 256,
   parameter int DATA_W       = 64,
   parameter int N_PAR_GROUPS = 8
);
   localparam int BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
   localparam int ADDR_W = $clog2(N_ENTRIES);

   logic                    mem_req;
   logic                    mem_gnt;
   logic                    mem_we;
   logic [BANK_W-1:0]       mem_bank;
   logic [ADDR_W-1:0]       mem_addr;
   logic                    rd_vld;
   logic [DATA_W-1:0]       rd_data;
   logic                    rd_valid_bit;
   logic [N_PAR_GROUPS-1:0] rd_par;

   modport master (
      output mem_req, mem_we, mem_bank, mem_addr,
      input  mem_gnt, rd_vld, rd_data, rd_valid_bit, rd_par
   );

   modport slave (
      input  mem_req, mem_we, mem_bank, mem_addr,
      output mem_gnt, rd_vld, rd_data, rd_valid_bit, rd_par
   );
endinterface
`default_nettype wire

// File: rtl/nx_tcam_multibank_scrub_seq.sv
`default_nettype none
// ============================================================================
// Module   : nx_tcam_multibank_scrub_seq
// Brief    : Background parity scrubber for a multi-bank TCAM; optional error
//            injection is enabled with the NX_SCRUB_FORCE_ERR_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module nx_tcam_multibank_scrub_seq #(
   parameter int N_BANKS      = 4,
   parameter int N_ENTRIES    = 256,
   parameter int DATA_W       = 64,
   parameter int N_PAR_GROUPS = 8,
   parameter int INTERVAL_W   = 32,
   parameter int CNT_W        = 16,
   localparam int BANK_W      = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
   localparam int ADDR_W      = $clog2(N_ENTRIES)
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  scrub_en,
   input  wire logic [1:0]            invalidate_mask,
   input  wire logic [INTERVAL_W-1:0] scrub_interval,
   input  wire logic                  cnt_clr,
   nx_tcam_multibank_scrub_seq_if.master mem,
   input  wire logic                  force_sbe,
   input  wire logic                  force_mbe,
   output logic [CNT_W-1:0]           sbe_cnt,
   output logic [CNT_W-1:0]           mbe_cnt,
   output logic [BANK_W-1:0]          err_bank,
   output logic [ADDR_W-1:0]          err_addr,
   output logic                       sbe_int,
   output logic                       mbe_int,
   output logic                       pass_done
);
   localparam int GRP_W = DATA_W / N_PAR_GROUPS;
   localparam int PC_W  = $clog2(N_PAR_GROUPS + 1);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N_BANKS - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ENTRIES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_RD_REQ, S_RD_WAIT, S_CHECK, S_WR_REQ, S_ADVANCE
   } state_t;

   state_t                  state;
   logic [INTERVAL_W-1:0]   ivl_cnt;
   logic [BANK_W-1:0]       bank_ptr;
   logic [ADDR_W-1:0]       addr_ptr;
   logic [DATA_W-1:0]       data_q;
   logic                    vbit_q;
   logic [N_PAR_GROUPS-1:0] par_q;
   logic [N_PAR_GROUPS-1:0] mism;
   logic [PC_W-1:0]         n_bad;
   logic                    err_sbe;
   logic                    err_mbe;

   // The pointer only moves in ADVANCE, while no request is outstanding.
   assign mem.mem_bank = bank_ptr;
   assign mem.mem_addr = addr_ptr;

`ifdef NX_SCRUB_FORCE_ERR_EN
   localparam int MBE_BIT = (N_PAR_GROUPS > 1) ? 1 : 0;
`else
   logic unused_force;
   assign unused_force = force_sbe | force_mbe;
`endif

   always_comb begin
      mism = '0;
      for (int g = 0; g < N_PAR_GROUPS; g++) begin
         mism[g] = par_q[g] ^ (^data_q[g*GRP_W +: GRP_W]);
      end
`ifdef NX_SCRUB_FORCE_ERR_EN
      if (vbit_q) begin
         if (force_mbe) begin
            mism[0]       = ~mism[0];
            mism[MBE_BIT] = ~mism[MBE_BIT];
         end else if (force_sbe) begin
            mism[0] = ~mism[0];
         end
      end
`endif
      n_bad = '0;
      for (int g = 0; g < N_PAR_GROUPS; g++) begin
         n_bad = n_bad + PC_W'(mism[g]);
      end
      err_sbe = vbit_q && (n_bad == PC_W'(1));
      err_mbe = vbit_q && (n_bad >  PC_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ivl_cnt     <= '0;
         bank_ptr    <= '0;
         addr_ptr    <= '0;
         data_q      <= '0;
         vbit_q      <= 1'b0;
         par_q       <= '0;
         mem.mem_req <= 1'b0;
         mem.mem_we  <= 1'b0;
         sbe_cnt     <= '0;
         mbe_cnt     <= '0;
         err_bank    <= '0;
         err_addr    <= '0;
         sbe_int     <= 1'b0;
         mbe_int     <= 1'b0;
         pass_done   <= 1'b0;
      end else begin
         sbe_int   <= 1'b0;
         mbe_int   <= 1'b0;
         pass_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (scrub_en) begin
                  state   <= S_WAIT;
                  ivl_cnt <= '0;
               end
            end
            S_WAIT: begin
               if (!scrub_en) begin
                  state <= S_IDLE;
               end else if (ivl_cnt == scrub_interval) begin
                  state       <= S_RD_REQ;
                  mem.mem_req <= 1'b1;
                  mem.mem_we  <= 1'b0;
               end else begin
                  ivl_cnt <= ivl_cnt + 1'b1;
               end
            end
            S_RD_REQ: begin
               // A grant in the same cycle as the disable still commits the read.
               if (mem.mem_gnt) begin
                  state       <= S_RD_WAIT;
                  mem.mem_req <= 1'b0;
               end else if (!scrub_en) begin
                  state       <= S_IDLE;
                  mem.mem_req <= 1'b0;
               end
            end
            S_RD_WAIT: begin
               if (mem.rd_vld) begin
                  data_q <= mem.rd_data;
                  vbit_q <= mem.rd_valid_bit;
                  par_q  <= mem.rd_par;
                  state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (err_sbe) begin
                  sbe_int  <= 1'b1;
                  err_bank <= bank_ptr;
                  err_addr <= addr_ptr;
                  if (sbe_cnt != '1) sbe_cnt <= sbe_cnt + 1'b1;
               end
               if (err_mbe) begin
                  mbe_int  <= 1'b1;
                  err_bank <= bank_ptr;
                  err_addr <= addr_ptr;
                  if (mbe_cnt != '1) mbe_cnt <= mbe_cnt + 1'b1;
               end
               if ((err_sbe && invalidate_mask[0]) || (err_mbe && invalidate_mask[1])) begin
                  state       <= S_WR_REQ;
                  mem.mem_req <= 1'b1;
                  mem.mem_we  <= 1'b1;
               end else begin
                  state <= S_ADVANCE;
               end
            end
            S_WR_REQ: begin
               if (mem.mem_gnt) begin
                  state       <= S_ADVANCE;
                  mem.mem_req <= 1'b0;
                  mem.mem_we  <= 1'b0;
               end
            end
            S_ADVANCE: begin
               if (addr_ptr == LAST_ADDR) begin
                  addr_ptr <= '0;
                  if (bank_ptr == LAST_BANK) begin
                     bank_ptr  <= '0;
                     pass_done <= 1'b1;
                  end else begin
                     bank_ptr <= bank_ptr + 1'b1;
                  end
               end else begin
                  addr_ptr <= addr_ptr + 1'b1;
               end
               ivl_cnt <= '0;
               state   <= scrub_en ? S_WAIT : S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         // Clear wins over any increment made above in the same cycle.
         if (cnt_clr) begin
            sbe_cnt <= '0;
            mbe_cnt <= '0;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_nx_tcam_multibank_scrub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nx_tcam_multibank_scrub_seq
// Brief    : Randomised bench with a transaction-level scrub model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nx_tcam_multibank_scrub_seq;
   localparam int NB   = 2;
   localparam int NE   = 4;
   localparam int DW   = 64;
   localparam int NG   = 8;
   localparam int IW   = 8;
   localparam int CW   = 2;
   localparam int GW   = DW / NG;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          scrub_en = 1'b0;
   logic [1:0]    invalidate_mask = 2'b00;
   logic [IW-1:0] scrub_interval = '0;
   logic          cnt_clr = 1'b0;
   logic          force_sbe = 1'b0;
   logic          force_mbe = 1'b0;
   logic [CW-1:0] sbe_cnt, mbe_cnt;
   logic [0:0]    err_bank;
   logic [1:0]    err_addr;
   logic          sbe_int, mbe_int, pass_done;

   always #5 clk = ~clk;

   nx_tcam_multibank_scrub_seq_if #(.N_BANKS(NB), .N_ENTRIES(NE), .DATA_W(DW), .N_PAR_GROUPS(NG)) bus ();

   nx_tcam_multibank_scrub_seq #(
      .N_BANKS(NB), .N_ENTRIES(NE), .DATA_W(DW), .N_PAR_GROUPS(NG),
      .INTERVAL_W(IW), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .invalidate_mask(invalidate_mask),
      .scrub_interval(scrub_interval), .cnt_clr(cnt_clr), .mem(bus.master),
      .force_sbe(force_sbe), .force_mbe(force_mbe), .sbe_cnt(sbe_cnt), .mbe_cnt(mbe_cnt),
      .err_bank(err_bank), .err_addr(err_addr), .sbe_int(sbe_int), .mbe_int(mbe_int),
      .pass_done(pass_done)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model state: next entry to scrub, counters, last error, pulse tallies.
   int exp_bank = 0, exp_addr = 0;
   int exp_sbe = 0, exp_mbe = 0, exp_eb = 0, exp_ea = 0;
   int exp_sbe_p = 0, exp_mbe_p = 0, exp_pass_p = 0;
   int obs_sbe_p = 0, obs_mbe_p = 0, obs_pass_p = 0;
   bit pend_wr = 0, outst = 0, inc_due = 0, last_wr = 0;
   int dly = 0, cyc = 0, prev_rd_cyc = -1, idle = 0;
   logic [DW-1:0] rsp_data;
   logic [NG-1:0] rsp_par, st_flip;
   bit st_valid = 0;
   bit prev_req = 0, prev_gnt = 0, prev_we = 0, prev_en = 0;
   logic [2:0] prev_loc = '0;

   function automatic logic [NG-1:0] parity_of(input logic [DW-1:0] d);
      logic [NG-1:0] p;
      for (int g = 0; g < NG; g++) p[g] = ^d[g*GW +: GW];
      return p;
   endfunction

   function automatic void advance_model();
      exp_addr++;
      if (exp_addr == NE) begin
         exp_addr = 0;
         exp_bank++;
         if (exp_bank == NB) begin
            exp_bank = 0;
            exp_pass_p++;
         end
      end
   endfunction

   task automatic run_cycle(input bit en, input int gnt_pct, input bit timed);
      bit gnt, inc_next, wr;
      logic [NG-1:0] mm;
      int k, a, b;
      @(negedge clk);
      cyc++;
      if (sbe_int)   obs_sbe_p++;
      if (mbe_int)   obs_mbe_p++;
      if (pass_done) obs_pass_p++;
      if (prev_req && !prev_gnt && (prev_we || prev_en))
         check_eq("req_hold", {bus.mem_req, bus.mem_we, bus.mem_bank, bus.mem_addr},
                  {1'b1, prev_we, prev_loc});

      scrub_en  = en;
      cnt_clr   = ($urandom_range(0, 29) == 0);
      force_sbe = ($urandom_range(0, 3) == 0);
      force_mbe = ($urandom_range(0, 3) == 0);
      bus.rd_vld       = 1'b0;
      bus.rd_data      = {$urandom, $urandom};
      bus.rd_par       = NG'($urandom);
      bus.rd_valid_bit = 1'($urandom);

      // Read return for a previously granted read.
      inc_next = 0;
      if (outst) begin
         if (dly == 1) begin
            bus.rd_vld       = 1'b1;
            bus.rd_data      = rsp_data;
            bus.rd_par       = rsp_par;
            bus.rd_valid_bit = st_valid;
            outst            = 0;
            inc_next         = 1;
         end else begin
            dly--;
         end
      end else if ($urandom_range(0, 7) == 0) begin
         bus.rd_vld = 1'b1;
      end

      gnt = ($urandom_range(1, 100) <= gnt_pct);
      bus.mem_gnt = gnt;
      if (bus.mem_req && gnt) begin
         idle = 0;
         if (!bus.mem_we) begin
            check_eq("rd_busy", {outst, pend_wr, inc_due}, 0);
            check_eq("rd_ptr", 64'({bus.mem_bank, bus.mem_addr}), 64'(exp_bank * NE + exp_addr));
            check_eq("sbe_cnt", sbe_cnt, exp_sbe);
            check_eq("mbe_cnt", mbe_cnt, exp_mbe);
            check_eq("err_loc", {err_bank, err_addr}, 64'(exp_eb * NE + exp_ea));
            check_eq("sbe_pulses", obs_sbe_p, exp_sbe_p);
            check_eq("mbe_pulses", obs_mbe_p, exp_mbe_p);
            check_eq("pass_pulses", obs_pass_p, exp_pass_p);
            if (timed && prev_rd_cyc >= 0)
               check_eq("rd_gap", cyc - prev_rd_cyc, 64'(scrub_interval) + 5 + last_wr);
            prev_rd_cyc = cyc;
            rsp_data = {$urandom, $urandom};
            st_valid = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
               0: st_flip = '0;
               1: st_flip = NG'(1) << $urandom_range(0, NG - 1);
               2: begin
                  a = $urandom_range(0, NG - 1);
                  b = (a + $urandom_range(1, NG - 1)) % NG;
                  st_flip = (NG'(1) << a) | (NG'(1) << b);
               end
               default: st_flip = NG'($urandom);
            endcase
            rsp_par = parity_of(rsp_data) ^ st_flip;
            outst   = 1;
            dly     = timed ? 1 : $urandom_range(1, 3);
         end else begin
            check_eq("wr_expected", pend_wr, 1);
            check_eq("wr_ptr", 64'({bus.mem_bank, bus.mem_addr}), 64'(exp_bank * NE + exp_addr));
            pend_wr = 0;
            advance_model();
         end
      end else if (en) begin
         idle++;
         if (idle > 300) begin
            check_eq("progress_timeout", 0, 1);
            idle = 0;
         end
      end

      // Classification of the entry sitting in the CHECK cycle.
      if (inc_due) begin
         mm = st_flip;
`ifdef NX_SCRUB_FORCE_ERR_EN
         if (st_valid) begin
            if (force_mbe)      mm = mm ^ NG'(3);
            else if (force_sbe) mm = mm ^ NG'(1);
         end
`endif
         k  = $countones(mm);
         wr = 0;
         if (st_valid && k == 1) begin
            exp_sbe_p++;
            if (exp_sbe < CMAX) exp_sbe++;
            exp_eb = exp_bank; exp_ea = exp_addr;
            wr = invalidate_mask[0];
         end else if (st_valid && k >= 2) begin
            exp_mbe_p++;
            if (exp_mbe < CMAX) exp_mbe++;
            exp_eb = exp_bank; exp_ea = exp_addr;
            wr = invalidate_mask[1];
         end
         last_wr = wr;
         if (wr) pend_wr = 1;
         else    advance_model();
      end
      if (cnt_clr) begin
         exp_sbe = 0;
         exp_mbe = 0;
      end
      inc_due = inc_next;

      prev_req = bus.mem_req;
      prev_gnt = gnt;
      prev_we  = bus.mem_we;
      prev_loc = {bus.mem_bank, bus.mem_addr};
      prev_en  = en;
   endtask

   initial begin
      bit timed;
      int gpct, drop;
      bus.mem_gnt = 1'b0;
      bus.rd_vld = 1'b0;
      bus.rd_data = '0;
      bus.rd_par = '0;
      bus.rd_valid_bit = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_req", {bus.mem_req, bus.mem_we, bus.mem_bank, bus.mem_addr}, 0);
      check_eq("rst_cnt", {sbe_cnt, mbe_cnt}, 0);
      check_eq("rst_err", {err_bank, err_addr}, 0);
      check_eq("rst_pulse", {sbe_int, mbe_int, pass_done}, 0);
      rst_n = 1'b1;

      for (int p = 0; p < 10; p++) begin
         timed           = (p % 3 == 1);
         scrub_interval  = IW'($urandom_range(0, 3));
         invalidate_mask = 2'($urandom);
         gpct            = timed ? 100 : $urandom_range(30, 100);
         prev_rd_cyc     = -1;
         drop            = 0;
         for (int c = 0; c < 500; c++) begin
            if (drop > 0) begin
               drop--;
               run_cycle(1'b0, gpct, timed);
            end else begin
               if (!timed && $urandom_range(0, 49) == 0) drop = $urandom_range(1, 10);
               run_cycle(1'b1, gpct, timed);
            end
         end
         for (int c = 0; c < 25; c++) run_cycle(1'b0, 100, 1'b0);
         check_eq("idle_req", bus.mem_req, 0);
         check_eq("drain_sbe_pulses", obs_sbe_p, exp_sbe_p);
         check_eq("drain_mbe_pulses", obs_mbe_p, exp_mbe_p);
         check_eq("drain_pass_pulses", obs_pass_p, exp_pass_p);
         check_eq("drain_cnts", {sbe_cnt, mbe_cnt}, {CW'(exp_sbe), CW'(exp_mbe)});
         check_eq("drain_err_loc", {err_bank, err_addr}, 64'(exp_eb * NE + exp_ea));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
`default_nettype wire
